// File: rtl/add_arb_pkg.sv
// rtl/add_arb_pkg.sv - shared types and defaults for the adder arbiter
// Purpose : FSM state encoding and default NREQ/DW for add_arbiter and rr_select.
// Ports   : none (package).
package add_arb_pkg;

  localparam int DEF_NREQ = 4;
  localparam int DEF_DW   = 64;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_WAIT_Z = 3'd2,
    ST_ACK    = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/rr_select.sv
// rtl/rr_select.sv - combinational round-robin winner selection
// Purpose : pick the first requester at or after (last_grant+1) mod NREQ.
// Ports   : req        - request levels, one per requester
//           last_grant - index served most recently
//           winner     - selected index (0 when valid is low)
//           valid      - at least one request is pending
module rr_select #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_grant,
  output logic [IW-1:0]   winner,
  output logic            valid
);

  int idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    // Offsets 1..NREQ visit every requester once; offset NREQ is last_grant
    // itself, so a lone requester can be served back to back.
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_grant) + k) % NREQ;
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/add_arbiter.sv
// rtl/add_arbiter.sv - round-robin arbiter sharing one adder among NREQ requesters
// Purpose : grant one requester, run one start/strobe/ack handshake with the
//           shared adder, return the result with a one-cycle done pulse.
// Ports   : clock, reset_n (async, active low)
//           req, a_bus, b_bus             - requester side inputs
//           done, z, grant_id, busy       - requester side outputs
//           add_start, add_a, add_b, add_ack / add_stb, add_z - adder handshake
//           op_count                      - completed-operation counter, only
//                                           present when ADD_ARB_STATS_EN is defined
module add_arbiter
  import add_arb_pkg::*;
#(
  parameter  int NREQ = DEF_NREQ,
  parameter  int DW   = DEF_DW,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*DW-1:0] a_bus,
  input  logic [NREQ*DW-1:0] b_bus,
  output logic [NREQ-1:0]   done,
  output logic [DW-1:0]     z,
  output logic [IW-1:0]     grant_id,
  output logic              busy,
  output logic              add_start,
  output logic [DW-1:0]     add_a,
  output logic [DW-1:0]     add_b,
  output logic              add_ack,
  input  logic              add_stb,
  input  logic [DW-1:0]     add_z
`ifdef ADD_ARB_STATS_EN
  ,
  output logic [31:0]       op_count
`endif
);

  state_e        state_q, state_d;
  logic [DW-1:0] a_q, a_d, b_q, b_d;
  logic [DW-1:0] res_q, res_d, z_q, z_d;
  logic [IW-1:0] grant_q, grant_d, last_q, last_d;
  logic [IW-1:0] win_idx;
  logic          win_vld;

  rr_select #(.NREQ(NREQ), .IW(IW)) u_rr_select (
    .req        (req),
    .last_grant (last_q),
    .winner     (win_idx),
    .valid      (win_vld)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    z_d     = z_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          grant_d = win_idx;
          a_d     = a_bus[int'(win_idx)*DW +: DW];
          b_d     = b_bus[int'(win_idx)*DW +: DW];
          state_d = ST_START;
        end
      end
      ST_START:  state_d = ST_WAIT_Z;
      ST_WAIT_Z: begin
        if (add_stb) begin
          res_d   = add_z;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        // The result is parked in res_q so z keeps the previous result
        // until the cycle this operation's done pulse appears.
        if (!add_stb) begin
          z_d     = res_q;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        last_d  = grant_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      z_q     <= '0;
      grant_q <= '0;
      last_q  <= IW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      z_q     <= z_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign add_start = (state_q == ST_START);
  assign add_ack   = (state_q == ST_ACK);
  assign done      = (state_q == ST_DONE) ? (NREQ'(1) << grant_q) : '0;
  assign z         = z_q;
  assign add_a     = a_q;
  assign add_b     = b_q;
  assign grant_id  = grant_q;

`ifdef ADD_ARB_STATS_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_DONE) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign op_count = cnt_q;
`endif

endmodule
